// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: sequential instruction fetch with prefetch FIFO, credit-limited requests and redirect flush
module instr_fetch_unit #(
    parameter int                 ADDR_W   = 13,
    parameter int                 DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    output logic [31:0]       inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready,
    output logic              fetch_fault
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {RUN, FAULT} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] fetch_pc, resp_pc, redir_pc;
    logic [CW-1:0]     count, outstanding, drop_cnt;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [31:0]       data_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem [DEPTH];
    logic              req_fire, push, pop;

    assign redir_pc      = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign mem_req_valid = rst && state == RUN && !redirect_valid &&
                           ({1'b0, count} + {1'b0, outstanding} < (CW+1)'(DEPTH));
    assign mem_req_addr  = fetch_pc;
    assign req_fire      = mem_req_valid && mem_req_ready;
    assign push          = mem_rsp_valid && drop_cnt == '0 && !redirect_valid;
    assign pop           = inst_valid && inst_ready && !redirect_valid;
    assign inst_valid    = count != '0;
    assign inst_data     = data_mem[rd_ptr];
    assign inst_pc       = pc_mem[rd_ptr];
    assign fetch_fault   = state == FAULT;

    // a redirect decides between running and halting on its alignment
    always_comb begin
        state_nxt = state;
        if (redirect_valid)
            state_nxt = (redirect_pc[1:0] != 2'b00) ? FAULT : RUN;
    end

    // state register
    always_ff @(posedge clk) begin
        state <= !rst ? RUN : state_nxt;
    end

    // in-flight accounting: every in-flight word at a redirect becomes stale and is dropped
    always_ff @(posedge clk) begin
        if (!rst) begin
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(mem_rsp_valid);
            drop_cnt    <= redirect_valid ? outstanding - CW'(mem_rsp_valid)
                                          : drop_cnt - CW'(mem_rsp_valid && drop_cnt != '0);
        end
    end

    // fetch pointer and prefetch FIFO; redirect clears the FIFO and restarts both PCs
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (redirect_valid) begin
            fetch_pc <= redir_pc;
            resp_pc  <= redir_pc;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            if (req_fire)
                fetch_pc <= fetch_pc + ADDR_W'(4);
            if (push) begin
                data_mem[wr_ptr] <= mem_rsp_data;
                pc_mem[wr_ptr]   <= resp_pc;
                wr_ptr           <= wr_ptr + PW'(1);
                resp_pc          <= resp_pc + ADDR_W'(4);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // the request credit must keep a kept response from ever meeting a full FIFO
    always_ff @(posedge clk) begin
        if (rst && push)
            assert (count < CW'(DEPTH)) else $error("prefetch fifo overflow");
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized and directed checks of the fetch unit against an epoch-based reference model
module tb_instr_fetch_unit;
    localparam int AW = 13;
    localparam int D  = 4;

    logic          clk = 0, rst = 0;
    logic          mem_req_valid, mem_req_ready, mem_rsp_valid;
    logic [AW-1:0] mem_req_addr, redirect_pc, inst_pc;
    logic [31:0]   mem_rsp_data, inst_data;
    logic          redirect_valid, inst_valid, inst_ready, fetch_fault;

    instr_fetch_unit #(.ADDR_W(AW), .DEPTH(D), .RESET_PC('0)) dut (
        .clk(clk), .rst(rst),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] addr; int ep; int due; } req_t;
    typedef struct { logic [AW-1:0] pc; logic [31:0] data; } ent_t;

    req_t          mq[$];
    ent_t          exp_q[$];
    logic [AW-1:0] fire_log[$], pop_log[$];
    logic [AW-1:0] next_addr;
    int            checks, failures, cyc, epoch, lat, jit, fire_cnt, pop_cnt;
    bit            rdy_rand, fault_m, obs_valid, obs_rsp, obs_req, obs_fault;

    function automatic logic [31:0] mword(logic [AW-1:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'hA5C3_0F17;
    endfunction

    // one clock: check outputs against the model, apply this edge's events, then drive the memory
    task automatic tick();
        req_t r;
        bit   exp_rv;
        @(negedge clk);
        obs_valid = inst_valid; obs_rsp = mem_rsp_valid; obs_req = mem_req_valid; obs_fault = fetch_fault;
        if (!rst) begin
            checks++;
            if ({mem_req_valid, inst_valid, fetch_fault} !== 3'b000 || inst_data !== 32'd0 || inst_pc !== '0) begin
                failures++;
                $display("FAIL reset_outputs got req=%b iv=%b ff=%b data=%h pc=%h want all zero",
                         mem_req_valid, inst_valid, fetch_fault, inst_data, inst_pc);
            end
        end else begin
            exp_rv = !fault_m && !redirect_valid && (mq.size() + exp_q.size() < D);
            checks++;
            if (mem_req_valid !== exp_rv) begin
                failures++;
                $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, mem_req_valid, exp_rv);
            end
            if (mem_req_valid === 1'b1 && exp_rv) begin
                checks++;
                if (mem_req_addr !== next_addr) begin
                    failures++;
                    $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, mem_req_addr, next_addr);
                end
            end
            checks++;
            if (inst_valid !== (exp_q.size() != 0)) begin
                failures++;
                $display("FAIL inst_valid cyc=%0d got=%b exp=%b", cyc, inst_valid, exp_q.size() != 0);
            end
            if (inst_valid === 1'b1 && exp_q.size() != 0) begin
                checks++;
                if (inst_pc !== exp_q[0].pc || inst_data !== exp_q[0].data) begin
                    failures++;
                    $display("FAIL inst_head cyc=%0d got pc=%h data=%h exp pc=%h data=%h",
                             cyc, inst_pc, inst_data, exp_q[0].pc, exp_q[0].data);
                end
            end
            checks++;
            if (fetch_fault !== fault_m) begin
                failures++;
                $display("FAIL fetch_fault cyc=%0d got=%b exp=%b", cyc, fetch_fault, fault_m);
            end
            if (inst_valid && inst_ready && !redirect_valid) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                pop_log.push_back(inst_pc);
                pop_cnt++;
            end
            if (mem_rsp_valid && mq.size() != 0) begin
                r = mq.pop_front();
                if (r.ep == epoch && !redirect_valid) exp_q.push_back('{r.addr, mword(r.addr)});
            end
            if (mem_req_valid && mem_req_ready) begin
                mq.push_back('{mem_req_addr, epoch, cyc + lat + int'($urandom_range(0, jit))});
                fire_log.push_back(mem_req_addr);
                fire_cnt++;
                next_addr = next_addr + AW'(4);
            end
            if (redirect_valid) begin
                epoch++;
                exp_q.delete();
                next_addr = {redirect_pc[AW-1:2], 2'b00};
                fault_m = redirect_pc[1:0] != 2'b00;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        mem_req_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (mq.size() != 0 && mq[0].due <= cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mword(mq[0].addr);
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = $urandom;
        end
    endtask

    task automatic do_reset();
        rst = 0; redirect_valid = 0; redirect_pc = '0; inst_ready = 0;
        mem_rsp_valid = 0; mem_rsp_data = '0; mem_req_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        mq.delete(); exp_q.delete(); fire_log.delete(); pop_log.delete();
        fault_m = 0; next_addr = '0; epoch++; fire_cnt = 0; pop_cnt = 0;
        tick();
        tick();
        rst = 1;
    endtask

    task automatic redirect(input logic [AW-1:0] pc);
        redirect_valid = 1; redirect_pc = pc;
        tick();
        redirect_valid = 0;
    endtask

    task automatic test_reset();
        rdy_rand = 0; lat = 1; jit = 0;
        do_reset();
        inst_ready = 1;
        tick();
        checks++;
        if (obs_valid !== 1'b0 || obs_req !== 1'b1) begin
            failures++; $display("FAIL first_cycle got iv=%b req=%b exp iv=0 req=1", obs_valid, obs_req);
        end
        tick();
        checks++;
        if (obs_valid !== 1'b0) begin failures++; $display("FAIL early_valid got=%b exp=0", obs_valid); end
        tick();
        checks++;
        if (obs_valid !== 1'b1) begin failures++; $display("FAIL first_valid_latency got=%b exp=1", obs_valid); end
        checks++;
        if (fire_log.size() == 0 || fire_log[0] !== '0) begin
            failures++; $display("FAIL first_addr got=%h exp=0", fire_log.size() != 0 ? fire_log[0] : 'x);
        end
    endtask

    task automatic test_stream();
        int p;
        do_reset();
        inst_ready = 1;
        repeat (5) tick();
        p = pop_cnt;
        repeat (20) tick();
        checks++;
        if (pop_cnt - p != 20) begin failures++; $display("FAIL stream_rate got=%0d exp=20", pop_cnt - p); end
        checks++;
        if (pop_log.size() < 11 || pop_log[10] !== AW'(40)) begin
            failures++; $display("FAIL stream_pc10 got=%h exp=28", pop_log.size() > 10 ? pop_log[10] : 'x);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        inst_ready = 0;
        repeat (10) tick();
        checks++;
        if (fire_cnt != D) begin failures++; $display("FAIL bp_requests got=%0d exp=%0d", fire_cnt, D); end
        checks++;
        if (fire_log.size() < 4 || fire_log[3] !== AW'(12)) begin
            failures++; $display("FAIL bp_last_addr got=%h exp=c", fire_log.size() > 3 ? fire_log[3] : 'x);
        end
        checks++;
        if (obs_req !== 1'b0) begin failures++; $display("FAIL bp_req_stalled got=%b exp=0", obs_req); end
        inst_ready = 1;
        repeat (10) tick();
        checks++;
        if (fire_log.size() < 5 || fire_log[4] !== AW'(16)) begin
            failures++; $display("FAIL bp_resume_addr got=%h exp=10", fire_log.size() > 4 ? fire_log[4] : 'x);
        end
        checks++;
        if (pop_log.size() < 5 || pop_log[3] !== AW'(12) || pop_log[4] !== AW'(16)) begin
            failures++; $display("FAIL bp_no_loss got=%h exp=c then 10", pop_log.size() > 3 ? pop_log[3] : 'x);
        end
    endtask

    task automatic test_stale_drop();
        do_reset();
        lat = 3;
        inst_ready = 1;
        tick();
        tick();
        checks++;
        if (fire_cnt != 2 || obs_rsp !== 1'b0) begin
            failures++; $display("FAIL stale_setup got fires=%0d rsp=%b exp 2 and 0", fire_cnt, obs_rsp);
        end
        redirect(AW'('h40));
        pop_log.delete();
        repeat (12) tick();
        checks++;
        if (pop_log.size() == 0 || pop_log[0] !== AW'('h40)) begin
            failures++; $display("FAIL stale_first_pc got=%h exp=40", pop_log.size() != 0 ? pop_log[0] : 'x);
        end
        lat = 1;
    endtask

    task automatic test_collide();
        do_reset();
        inst_ready = 1;
        repeat (8) tick();
        redirect(AW'('h100));
        checks++;
        if (obs_rsp !== 1'b1 || obs_valid !== 1'b1) begin
            failures++; $display("FAIL collide_setup got rsp=%b iv=%b exp 1 1", obs_rsp, obs_valid);
        end
        pop_log.delete();
        tick();
        checks++;
        if (obs_valid !== 1'b0) begin failures++; $display("FAIL collide_flush got=%b exp=0", obs_valid); end
        repeat (6) tick();
        checks++;
        if (pop_log.size() == 0 || pop_log[0] !== AW'('h100)) begin
            failures++; $display("FAIL collide_first_pc got=%h exp=100", pop_log.size() != 0 ? pop_log[0] : 'x);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        inst_ready = 1;
        redirect(AW'('h1FF0));
        fire_log.delete();
        repeat (8) tick();
        checks++;
        if (fire_log.size() < 5 || fire_log[3] !== AW'('h1FFC) || fire_log[4] !== AW'(0)) begin
            failures++; $display("FAIL wrap_addr got=%h exp=0", fire_log.size() > 4 ? fire_log[4] : 'x);
        end
    endtask

    task automatic test_fault();
        int f;
        do_reset();
        inst_ready = 1;
        repeat (4) tick();
        redirect(AW'('h42));
        tick();
        checks++;
        if (obs_fault !== 1'b1 || obs_req !== 1'b0 || obs_valid !== 1'b0) begin
            failures++; $display("FAIL fault_halt got ff=%b req=%b iv=%b exp 1 0 0", obs_fault, obs_req, obs_valid);
        end
        f = fire_cnt;
        repeat (5) tick();
        checks++;
        if (fire_cnt != f) begin failures++; $display("FAIL fault_no_fetch got=%0d exp=%0d", fire_cnt, f); end
        redirect(AW'('h80));
        fire_log.delete();
        tick();
        checks++;
        if (obs_fault !== 1'b0) begin failures++; $display("FAIL fault_clear got=%b exp=0", obs_fault); end
        repeat (4) tick();
        checks++;
        if (fire_log.size() == 0 || fire_log[0] !== AW'('h80)) begin
            failures++; $display("FAIL fault_resume got=%h exp=80", fire_log.size() != 0 ? fire_log[0] : 'x);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] pc;
        do_reset();
        rdy_rand = 1; lat = 1; jit = 3;
        for (int i = 0; i < 800; i++) begin
            inst_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 24) == 0) begin
                pc = AW'($urandom);
                if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
                redirect(pc);
            end else begin
                tick();
            end
        end
        checks++;
        if (pop_cnt == 0) begin failures++; $display("FAIL random_progress got=0 exp>0"); end
        rdy_rand = 0; jit = 0;
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0; epoch = 0;
        rdy_rand = 0; lat = 1; jit = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_stale_drop();
        test_collide();
        test_wrap();
        test_fault();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
